// File: rtl/line_draw_scheduler_if.sv
// rtl/line_draw_scheduler_if.sv - request/pixel bus between two line requesters and the scheduler
// Signals: req/x0/y0/x1/y1/color per requester A and B (in to scheduler),
//          ack/done pulses per requester, pixel stream x/y/pixel_color/pixel_we, busy, owner (out).
// Modports: master = requester/pixel-sink side, slave = scheduler side.

interface line_draw_scheduler_if;
    logic        req_a, req_b;
    logic [10:0] x0_a, y0_a, x1_a, y1_a;
    logic [10:0] x0_b, y0_b, x1_b, y1_b;
    logic        color_a, color_b;
    logic        ack_a, ack_b;
    logic        done_a, done_b;
    logic [10:0] x, y;
    logic        pixel_color;
    logic        pixel_we;
    logic        busy;
    logic        owner;

    modport master (
        output req_a, req_b, x0_a, y0_a, x1_a, y1_a, x0_b, y0_b, x1_b, y1_b, color_a, color_b,
        input  ack_a, ack_b, done_a, done_b, x, y, pixel_color, pixel_we, busy, owner
    );

    modport slave (
        input  req_a, req_b, x0_a, y0_a, x1_a, y1_a, x0_b, y0_b, x1_b, y1_b, color_a, color_b,
        output ack_a, ack_b, done_a, done_b, x, y, pixel_color, pixel_we, busy, owner
    );
endinterface

// File: rtl/line_draw_scheduler.sv
// rtl/line_draw_scheduler.sv - round-robin two-requester line scheduler driving one Bresenham drawer
// line_drawer ports: clk, reset (loads start point), x0/y0/x1/y1 endpoints, step_i (advance one pixel),
//                    x_o/y_o current pixel.
// line_draw_scheduler ports: clk, reset (sync, active-high), bus (slave modport of line_draw_scheduler_if).

module line_drawer (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic        step_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o
);
    logic [10:0]        adx, ady;
    logic signed [15:0] dx_s, dy_s, e2;
    logic signed [15:0] err_q, err_d;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic               step_x, step_y;

    assign adx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
    assign ady  = (y1 >= y0) ? y1 - y0 : y0 - y1;
    assign dx_s = $signed({5'b0, adx});
    assign dy_s = -$signed({5'b0, ady});
    // Both axis decisions use the error from before this step (all-octant Bresenham).
    assign e2     = err_q <<< 1;
    assign step_x = (e2 >= dy_s);
    assign step_y = (e2 <= dx_s);

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        err_d = err_q;
        if (step_i) begin
            if (step_x) x_d = (x1 >= x0) ? x_q + 11'd1 : x_q - 11'd1;
            if (step_y) y_d = (y1 >= y0) ? y_q + 11'd1 : y_q - 11'd1;
            err_d = err_q + (step_x ? dy_s : 16'sd0) + (step_y ? dx_s : 16'sd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= x0;
            y_q   <= y0;
            err_q <= dx_s + dy_s;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

module line_draw_scheduler (
    input  logic                 clk,
    input  logic                 reset,
    line_draw_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DRAW, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;      // requester served most recently (1 = B)
    logic        color_q, color_d;
    logic [10:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic        grant_b;
    logic        at_end;
    logic        drawer_reset;
    logic [10:0] drw_x, drw_y;

    // Lone request wins; on a tie the requester not served last wins.
    assign grant_b = (bus.req_a && bus.req_b) ? ~last_q : bus.req_b;
    assign at_end  = (drw_x == x1_q) && (drw_y == y1_q);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        color_d = color_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        case (state_q)
            IDLE: begin
                if (bus.req_a || bus.req_b) begin
                    owner_d = grant_b;
                    color_d = grant_b ? bus.color_b : bus.color_a;
                    x0_d    = grant_b ? bus.x0_b : bus.x0_a;
                    y0_d    = grant_b ? bus.y0_b : bus.y0_a;
                    x1_d    = grant_b ? bus.x1_b : bus.x1_a;
                    y1_d    = grant_b ? bus.y1_b : bus.y1_a;
                    state_d = START;
                end
            end
            START: state_d = DRAW;
            DRAW: begin
                if (at_end) begin
                    state_d = DONE;
                    last_d  = owner_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;          // so that A wins the first tie
            color_q <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            color_q <= color_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
        end
    end

    // START loads the start point so the first DRAW cycle shows (x0, y0).
    assign drawer_reset = reset || (state_q == START);

    line_drawer u_drawer (
        .clk    (clk),
        .reset  (drawer_reset),
        .x0     (x0_q),
        .y0     (y0_q),
        .x1     (x1_q),
        .y1     (y1_q),
        .step_i (state_q == DRAW),
        .x_o    (drw_x),
        .y_o    (drw_y)
    );

    assign bus.ack_a       = (state_q == START) && !owner_q;
    assign bus.ack_b       = (state_q == START) &&  owner_q;
    assign bus.done_a      = (state_q == DONE)  && !owner_q;
    assign bus.done_b      = (state_q == DONE)  &&  owner_q;
    assign bus.pixel_we    = (state_q == DRAW);
    assign bus.x           = bus.pixel_we ? drw_x : 11'd0;
    assign bus.y           = bus.pixel_we ? drw_y : 11'd0;
    assign bus.pixel_color = bus.pixel_we && color_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.owner       = owner_q;
endmodule

// File: tb/tb_line_draw_scheduler.sv
// tb/tb_line_draw_scheduler.sv - self-checking bench for line_draw_scheduler

module tb_line_draw_scheduler;
    typedef struct {
        bit          who;
        logic [10:0] x0, y0, x1, y1;
        bit          c;
    } line_t;

    typedef struct {
        line_t ln;
        int    exp_pixels;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    line_draw_scheduler_if ldi();
    line_draw_scheduler dut (.clk(clk), .reset(reset), .bus(ldi));

    int checks = 0;
    int fails  = 0;
    bit mon_en = 0;
    bit model_last;

    bit    k_scramble = 0;
    bit    k_keep     = 0;
    int    k_raise    = -1;
    int    k_drop     = -1;
    line_t k_other;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int isgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int npix(input line_t l);
        int ax, ay;
        ax = iabs(int'(l.x1) - int'(l.x0));
        ay = iabs(int'(l.y1) - int'(l.y0));
        return ((ax > ay) ? ax : ay) + 1;
    endfunction

    function automatic line_t mk(input bit who, input int x0, input int y0, input int x1, input int y1, input bit c);
        line_t l;
        l.who = who; l.x0 = 11'(x0); l.y0 = 11'(y0); l.x1 = 11'(x1); l.y1 = 11'(y1); l.c = c;
        return l;
    endfunction

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
    endfunction

    function automatic line_t rand_line(input bit who);
        line_t l;
        l.who = who;
        l.x0  = 11'($urandom);
        l.y0  = 11'($urandom);
        l.x1  = 11'(clampc(int'(l.x0) + int'($urandom_range(0, 60)) - 30));
        l.y1  = 11'(clampc(int'(l.y0) + int'($urandom_range(0, 60)) - 30));
        if ($urandom_range(0, 7) == 0) begin
            l.x1 = l.x0;
            l.y1 = l.y0;
        end
        l.c = 1'($urandom);
        return l;
    endfunction

    // Every cycle: exclusive grants/dones, pixel bus zeroed when not writing, no write outside DRAW.
    always @(negedge clk) begin
        if (mon_en) begin
            int bad;
            bad = 0;
            if (ldi.ack_a && ldi.ack_b) bad++;
            if (ldi.done_a && ldi.done_b) bad++;
            if (!ldi.pixel_we && (ldi.x != 0 || ldi.y != 0 || ldi.pixel_color)) bad++;
            if (ldi.pixel_we && (ldi.ack_a || ldi.ack_b || ldi.done_a || ldi.done_b || !ldi.busy)) bad++;
            if ((ldi.ack_a || ldi.ack_b || ldi.done_a || ldi.done_b) && !ldi.busy) bad++;
            chk("cycle_invariants", bad, 0);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input line_t l);
        if (l.who) begin
            ldi.x0_b = l.x0; ldi.y0_b = l.y0; ldi.x1_b = l.x1; ldi.y1_b = l.y1;
            ldi.color_b = l.c; ldi.req_b = 1'b1;
        end else begin
            ldi.x0_a = l.x0; ldi.y0_a = l.y0; ldi.x1_a = l.x1; ldi.y1_a = l.y1;
            ldi.color_a = l.c; ldi.req_a = 1'b1;
        end
    endtask

    task automatic scramble(input bit who);
        if (who) begin
            ldi.x0_b = 11'($urandom); ldi.y0_b = 11'($urandom);
            ldi.x1_b = 11'($urandom); ldi.y1_b = 11'($urandom); ldi.color_b = 1'($urandom);
        end else begin
            ldi.x0_a = 11'($urandom); ldi.y0_a = 11'($urandom);
            ldi.x1_a = 11'($urandom); ldi.y1_a = 11'($urandom); ldi.color_a = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        ldi.req_a = 1'b0;
        ldi.req_b = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
    endtask

    // Requester l.who already has req raised. Waits for its grant, collects the pixel
    // stream until done and checks it against the ideal line; returns at the IDLE cycle.
    task automatic serve(input line_t l, output int ack_wait, output int n_pix);
        int  qx[$];
        int  qy[$];
        int  np, cyc, bad, dxs, dys, maj, dev, sx, sy;
        bit  got;
        ack_wait = 0;
        n_pix    = 0;
        got      = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ack_wait++;
            if (ldi.ack_a || ldi.ack_b) begin
                got = 1;
                break;
            end
        end
        chk("ack_seen", got, 1);
        if (got) begin
            chk("ack_owner", ldi.ack_b, l.who);
            chk("owner_in_start", ldi.owner, l.who);
            if (!k_keep) begin
                if (l.who) ldi.req_b = 1'b0; else ldi.req_a = 1'b0;
            end
            if (k_scramble) scramble(l.who);
            np  = npix(l);
            cyc = 0;
            bad = 0;
            got = 0;
            while (cyc < np + 10) begin
                @(negedge clk);
                cyc++;
                if (ldi.ack_a || ldi.ack_b) bad++;
                if (ldi.pixel_we) begin
                    qx.push_back(int'(ldi.x));
                    qy.push_back(int'(ldi.y));
                    if (ldi.pixel_color !== l.c) bad++;
                    if (ldi.owner !== l.who) bad++;
                end
                if (cyc - 1 == k_raise) drive(k_other);
                if (cyc - 1 == k_drop) begin
                    if (k_other.who) ldi.req_b = 1'b0; else ldi.req_a = 1'b0;
                end
                if (ldi.done_a || ldi.done_b) begin
                    got = 1;
                    break;
                end
            end
            chk("done_seen", got, 1);
            if (got) begin
                chk("done_owner", ldi.done_b, l.who);
                chk("done_latency", cyc, np + 1);
                model_last = l.who;
            end
            n_pix = qx.size();
            chk("pixel_count", n_pix, np);
            if (n_pix > 0) begin
                chk("first_x", qx[0], l.x0);
                chk("first_y", qy[0], l.y0);
                chk("last_x", qx[n_pix-1], l.x1);
                chk("last_y", qy[n_pix-1], l.y1);
            end
            dxs = int'(l.x1) - int'(l.x0);
            dys = int'(l.y1) - int'(l.y0);
            maj = (iabs(dxs) > iabs(dys)) ? iabs(dxs) : iabs(dys);
            for (int i = 0; i < n_pix; i++) begin
                dev = (qy[i] - int'(l.y0)) * dxs - (qx[i] - int'(l.x0)) * dys;
                if (2 * iabs(dev) > maj) bad++;
                if (i > 0) begin
                    sx = qx[i] - qx[i-1];
                    sy = qy[i] - qy[i-1];
                    if (sx != 0 && sx != isgn(dxs)) bad++;
                    if (sy != 0 && sy != isgn(dys)) bad++;
                    if (sx == 0 && sy == 0) bad++;
                end
            end
            chk("line_shape", bad, 0);
            @(negedge clk);
            chk("idle_after_done", ldi.busy, 0);
        end
        k_scramble = 0;
        k_keep     = 0;
        k_raise    = -1;
        k_drop     = -1;
    endtask

    vec_t  vecs[8];
    line_t la, lb, lw, ll;
    int    aw, np, cnt, mode;
    bit    win;

    initial begin
        vecs[0] = '{mk(0, 0, 0, 3, 2, 1), 4};
        vecs[1] = '{mk(1, 5, 5, 5, 5, 0), 1};
        vecs[2] = '{mk(0, 10, 10, 0, 0, 1), 11};
        vecs[3] = '{mk(1, 0, 20, 3, 0, 1), 21};
        vecs[4] = '{mk(0, 2047, 2047, 2047, 2040, 0), 8};
        vecs[5] = '{mk(1, 2047, 0, 0, 3, 1), 2048};
        vecs[6] = '{mk(0, 0, 2047, 2047, 0, 0), 2048};
        vecs[7] = '{mk(1, 7, 3, 1, 9, 1), 7};

        ldi.req_a = 0; ldi.req_b = 0;
        ldi.x0_a = 0; ldi.y0_a = 0; ldi.x1_a = 0; ldi.y1_a = 0; ldi.color_a = 0;
        ldi.x0_b = 0; ldi.y0_b = 0; ldi.x1_b = 0; ldi.y1_b = 0; ldi.color_b = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", ldi.busy, 0);
        chk("rst_ack", {ldi.ack_a, ldi.ack_b}, 0);
        chk("rst_done", {ldi.done_a, ldi.done_b}, 0);
        chk("rst_pixel", {ldi.pixel_we, ldi.pixel_color, ldi.x, ldi.y}, 0);
        chk("rst_owner", ldi.owner, 0);
        do_reset();
        mon_en = 1;

        // Lone A line (0,0)->(3,2) white.
        la = mk(0, 0, 0, 3, 2, 1);
        drive(la);
        serve(la, aw, np);
        chk("s1_ack_latency", aw, 1);

        // Reset mid-DRAW discards the line and re-arms A for the next tie.
        la = mk(0, 0, 0, 10, 15, 1);
        drive(la);
        cnt = 0;
        for (int i = 0; i < 10 && !ldi.ack_a; i++) @(negedge clk);
        chk("s5_ack_a", ldi.ack_a, 1);
        ldi.req_a = 0;
        repeat (3) @(negedge clk);
        chk("s5_drawing", ldi.pixel_we, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
        chk("s5_we_after_rst", ldi.pixel_we, 0);
        chk("s5_busy_after_rst", ldi.busy, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ldi.done_a || ldi.done_b || ldi.ack_a || ldi.ack_b || ldi.pixel_we) cnt++;
        end
        chk("s5_no_activity", cnt, 0);
        la = mk(0, 1, 2, 6, 4, 1);
        lb = mk(1, 9, 9, 4, 12, 0);
        drive(la); drive(lb);
        serve(la, aw, np);
        serve(lb, aw, np);
        chk("s5_b_after_idle", aw, 1);

        // Tie right after reset: A first, B after one IDLE cycle.
        do_reset();
        la = mk(0, 20, 30, 25, 33, 0);
        lb = mk(1, 40, 40, 38, 44, 1);
        drive(la); drive(lb);
        serve(la, aw, np);
        serve(lb, aw, np);
        chk("s2_b_ack_wait", aw, 1);

        // Four tied rounds alternate A, B, A, B.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            la = mk(0, r, 0, r + 3, 1, 1);
            lb = mk(1, 50, r, 52, r + 4, 0);
            drive(la); drive(lb);
            if (r % 2 == 0) serve(la, aw, np); else serve(lb, aw, np);
        end
        ldi.req_a = 0; ldi.req_b = 0;

        // Degenerate B line.
        lb = mk(1, 5, 5, 5, 5, 0);
        drive(lb);
        serve(lb, aw, np);
        chk("s4_one_pixel", np, 1);

        // B requests while A draws; A's inputs are disturbed after its grant.
        la = mk(0, 100, 200, 130, 190, 1);
        k_other = mk(1, 300, 300, 290, 310, 0);
        drive(la);
        k_scramble = 1;
        k_raise = 3;
        serve(la, aw, np);
        scramble(0);
        serve(k_other, aw, np);
        chk("s6_b_ack_wait", aw, 1);

        // A request raised and dropped while busy is never granted.
        lb = mk(1, 0, 0, 20, 0, 1);
        k_other = mk(0, 7, 7, 9, 9, 1);
        drive(lb);
        k_raise = 2;
        k_drop = 5;
        serve(lb, aw, np);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ldi.ack_a || ldi.ack_b) cnt++;
        end
        chk("dropped_req_ignored", cnt, 0);

        // req held past ack counts as a fresh request at the next IDLE.
        la = mk(0, 60, 60, 62, 61, 1);
        drive(la);
        k_keep = 1;
        serve(la, aw, np);
        serve(la, aw, np);
        chk("held_req_regrant", aw, 1);

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].ln);
            serve(vecs[v].ln, aw, np);
            chk("vec_ack_latency", aw, 1);
            chk("vec_pixels", np, vecs[v].exp_pixels);
        end

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            la = rand_line(0);
            lb = rand_line(1);
            if (mode != 1) drive(la);
            if (mode != 0) drive(lb);
            win = (mode == 2) ? !model_last : (mode == 1);
            lw = win ? lb : la;
            ll = win ? la : lb;
            k_scramble = 1'($urandom);
            serve(lw, aw, np);
            chk("rnd_ack_latency", aw, 1);
            if (mode == 2) begin
                serve(ll, aw, np);
                chk("rnd_loser_wait", aw, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/line_draw_scheduler.md
LINE_DRAW_SCHEDULER -- requirements
Module: line_draw_scheduler

Interface
REQ-001 clk  input  1  system clock; all logic on posedge clk.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 req_a, req_b  input  1 each  line request from requester A / B.
REQ-004 x0_a, y0_a, x1_a, y1_a  input  11 each  requester A start (x0,y0) and end (x1,y1) coordinates.
REQ-005 x0_b, y0_b, x1_b, y1_b  input  11 each  requester B start and end coordinates.
REQ-006 color_a, color_b  input  1 each  pixel colour for the requested line: 0 black, 1 white.
REQ-007 ack_a, ack_b  output  1 each  one-cycle grant pulse; request coordinates and colour are captured.
REQ-008 done_a, done_b  output  1 each  one-cycle pulse; that requester's line is fully emitted.
REQ-009 x, y  output  11 each  pixel coordinate to write.
REQ-010 pixel_color  output  1  colour of the pixel at (x, y).
REQ-011 pixel_we  output  1  pixel write strobe; (x, y, pixel_color) is valid only when this is 1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 owner  output  1  requester of the current line: 0 = A, 1 = B; holds its last value while IDLE.

Function
REQ-014 Shall instantiate one line_drawer; drawer reset, x0, y0, x1, y1 are driven only by this block.
REQ-015 FSM states: IDLE, START, DRAW, DONE.
REQ-016 IDLE: req_a/req_b sampled each edge; if any is high, latch the winner's coordinates, colour and owner, then go to START.
REQ-017 Arbitration is round-robin: one request alone wins; on a tie, the requester not served last wins.
REQ-018 The round-robin pointer updates on entry to DONE.
REQ-019 START lasts exactly one cycle: ack_<owner>=1, drawer reset=1, pixel_we=0; next state DRAW.
REQ-020 DRAW: pixel_we=1, x/y = drawer outputs, pixel_color = latched colour; one pixel per cycle, first pixel = (x0,y0).
REQ-021 DRAW ends in the cycle x==latched x1 and y==latched y1; that pixel is written (pixel_we=1) and the next state is DONE.
REQ-022 DONE lasts exactly one cycle: done_<owner>=1, pixel_we=0; next state IDLE.
REQ-023 Latency: req sampled at edge N -> ack during cycle N+1 -> first pixel in cycle N+2.
REQ-024 Latency (cont.): a line of P pixels -> done pulse in cycle N+2+P.
REQ-025 Minimum one IDLE cycle between consecutive lines; a request is never sampled outside IDLE.
REQ-026 Requester holds req and its inputs stable until ack, then deasserts req in the ack cycle.
REQ-027 A req still high after the ack cycle is treated as a new request at the next IDLE.
REQ-028 Input changes after the latch edge do not affect the line in progress.
REQ-029 A request dropped before ack is ignored: no ack, no pixels.
REQ-030 Degenerate line (x0==x1, y0==y1) yields exactly one DRAW cycle.
REQ-031 When pixel_we=0, x, y and pixel_color are forced to 0.
REQ-032 ack_a/ack_b never assert together; done_a/done_b never assert together.

Reset
REQ-033 On reset: state IDLE; ack, done, pixel_we, busy, x, y, pixel_color = 0; owner=0.
REQ-034 On reset, the round-robin pointer is set so that A wins the first tie.
REQ-035 Reset in any state, including mid-DRAW, takes effect at the next edge: no done pulse, no further pixel_we, latched line discarded.

Verification
REQ-036 Scenario 1: req_a, (0,0)->(3,2), colour 1 -> ack_a one cycle; then 4 pixel_we cycles, first (0,0), last (3,2), colour 1; then done_a one cycle; busy low after.
REQ-037 Scenario 2: req_a and req_b high at the same edge after reset -> A's full line, done_a, one IDLE cycle, then ack_b and B's line; pixel_we never asserted in START/DONE/IDLE.
REQ-038 Scenario 3: req_a and req_b re-asserted together after every done, 4 rounds -> grant order A, B, A, B.
REQ-039 Scenario 4: req_b, (5,5)->(5,5), colour 0 -> exactly one pixel_we cycle at (5,5) with colour 0, then done_b.
REQ-040 Scenario 5: reset pulsed during DRAW of A line (0,0)->(10,15) -> next cycle pixel_we=0, busy=0, no done_a; next tie grants A.
REQ-041 Scenario 6: req_b asserted while A's line is drawing -> no ack_b until A's done; ack_b on the first edge after return to IDLE; B's coordinates are used even if A's inputs change.
